// File: rtl/vpu_pkg.sv
// Shared constants for the VPU instruction memory: default width, FSM states, fault codes.
package vpu_pkg;

   localparam int unsigned INSTR_W_DEF = 32;

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [1:0] FLT_OK       = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE    = 2'b10;

endpackage

// File: rtl/vpu_imem_ram.sv
// Single write port / single read port RAM with a registered read; contents are never reset.
module vpu_imem_ram #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 32,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_re,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/vpu_instr_mem.sv
// Runtime-loadable instruction memory: LOAD streams the program in, RUN serves PC fetches
// with a 1-cycle registered response and per-fetch fault codes.
module vpu_instr_mem
   import vpu_pkg::*;
#(
   parameter int unsigned          DEPTH     = 64,
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          INSTR_W   = INSTR_W_DEF,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = '0,
   localparam int unsigned         PW_W      = $clog2(DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_reload,
   input  logic               i_ld_valid,
   output logic               o_ld_ready,
   input  logic [INSTR_W-1:0] i_ld_data,
   input  logic               i_ld_last,
   input  logic               i_fetch_valid,
   output logic               o_fetch_ready,
   input  logic [ADDR_W-1:0]  i_fetch_pc,
   output logic               o_resp_valid,
   input  logic               i_resp_ready,
   output logic [INSTR_W-1:0] o_resp_instr,
   output logic [1:0]         o_resp_fault,
   output logic [PW_W-1:0]    o_prog_words
);

   localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BYTE_SH = $clog2(INSTR_W / 8);

   logic [0:0]         r_state;
   logic [PW_W-1:0]    r_prog_words;
   logic               r_resp_valid;
   logic [1:0]         r_resp_fault;
   logic               r_use_ram;

   logic               w_ld_acc;
   logic               w_ld_done;
   logic               w_fetch_ready;
   logic               w_fetch_acc;
   logic [ADDR_W-1:0]  w_word;
   logic               w_misalign;
   logic               w_range;
   logic [1:0]         w_fault;
   logic [INSTR_W-1:0] w_rdata;

   assign w_ld_acc      = (r_state == ST_LOAD) && !i_reload && i_ld_valid;
   assign w_ld_done     = i_ld_last || (r_prog_words == PW_W'(DEPTH - 1));
   assign w_fetch_ready = (r_state == ST_RUN) && !i_reload && (!r_resp_valid || i_resp_ready);
   assign w_fetch_acc   = i_fetch_valid && w_fetch_ready;

   assign w_word     = i_fetch_pc >> BYTE_SH;
   assign w_misalign = |(i_fetch_pc & ADDR_W'(INSTR_W / 8 - 1));
   assign w_range    = (w_word >= ADDR_W'(r_prog_words));
   assign w_fault    = w_misalign ? FLT_MISALIGN : (w_range ? FLT_RANGE : FLT_OK);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_LOAD;
         r_prog_words <= '0;
         r_resp_valid <= 1'b0;
         r_resp_fault <= FLT_OK;
         r_use_ram    <= 1'b0;
      end else if (i_reload) begin
         r_state      <= ST_LOAD;
         r_prog_words <= '0;
         r_resp_valid <= 1'b0;
      end else begin
         if (w_ld_acc) begin
            r_prog_words <= r_prog_words + 1'b1;
            if (w_ld_done) r_state <= ST_RUN;
         end
         if (w_fetch_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_fault <= w_fault;
            r_use_ram    <= (w_fault == FLT_OK);
         end else if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
         end
      end
   end

   // RAM is only read on good fetches, so its output register doubles as the held response.
   vpu_imem_ram #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_ld_acc),
      .i_waddr (r_prog_words[AW-1:0]),
      .i_wdata (i_ld_data),
      .i_re    (w_fetch_acc && (w_fault == FLT_OK)),
      .i_raddr (w_word[AW-1:0]),
      .o_rdata (w_rdata)
   );

   assign o_ld_ready    = w_ld_acc || ((r_state == ST_LOAD) && !i_reload);
   assign o_fetch_ready = w_fetch_ready;
   assign o_resp_valid  = r_resp_valid;
   assign o_resp_fault  = r_resp_fault;
   assign o_prog_words  = r_prog_words;
   assign o_resp_instr  = r_use_ram ? w_rdata
                        : ((r_resp_fault == FLT_OK) ? '0 : NOP_INSTR);

endmodule
